// File: rtl/axis_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_fifo_arb_pkg
// Shared types and helpers for the AXI-Stream to FIFO round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   clog2()     : constant-function log2 used to size grant/pointer registers
// ---------------------------------------------------------------------------
package axis_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : axis_fifo_arb_pkg

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
// Combinational round-robin selector: returns the first asserted request
// found at ptr+1, ptr+2, ... (mod N_CH). The pointer channel itself is the
// last candidate, so a channel that just finished is only re-picked when
// nobody else is requesting.
// Ports:
//   req_i [N_CH]  per-channel request
//   ptr_i         last-served channel
//   idx_o         selected channel (0 when nothing requests)
//   any_o         at least one request is asserted
// ---------------------------------------------------------------------------
module axis_rr_pick
    import axis_fifo_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int GW   = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int cand;
        cand  = 0;
        idx_o = '0;
        any_o = |req_i;
        // Walk from the farthest candidate to the nearest so that the
        // nearest requester after ptr is the one left in idx_o.
        for (int k = N_CH; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % N_CH;
            if (req_i[cand]) begin
                idx_o = cand[GW-1:0];
            end
        end
    end

endmodule : axis_rr_pick

// File: rtl/axis_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// axis_fifo_arbiter
// Round-robin arbiter sharing one FIFO write port between N_CH AXI-Stream
// slave inputs. One channel is granted at a time for up to cfg_burst words
// (0 counts as 1). A grant ends after the last burst word or on the first
// cycle the granted channel's tvalid is low; FIFO full only stalls.
// Arbitration costs one bubble cycle in IDLE.
//
// Ports:
//   aclk, areset      clock / asynchronous active-high reset
//   cfg_burst         max words per grant, sampled when a grant starts
//   s_axis_tdata      channel i in [i*W +: W]
//   s_axis_tvalid     per-channel valid
//   s_axis_tready     per-channel ready (only the granted bit can be 1)
//   fifo_write_full   FIFO full flag
//   fifo_write_data   granted channel's data while wren=1, else 0
//   fifo_write_wren   FIFO write enable
//   sts_grant         current or last granted channel
//   sts_busy          1 while in GRANT
//   sts_words         per-channel 32-bit accepted-word counters
//
// Build option: define ARB_STATS_EN to include the sts_words counters;
// otherwise sts_words is tied to 0.
// ---------------------------------------------------------------------------
module axis_fifo_arbiter
    import axis_fifo_arb_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BURST_WIDTH      = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [BURST_WIDTH-1:0]           cfg_burst,
    input  logic [N_CH*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]                  s_axis_tvalid,
    output logic [N_CH-1:0]                  s_axis_tready,
    input  logic                             fifo_write_full,
    output logic [AXIS_TDATA_WIDTH-1:0]      fifo_write_data,
    output logic                             fifo_write_wren,
    output logic [clog2(N_CH)-1:0]           sts_grant,
    output logic                             sts_busy,
    output logic [N_CH*32-1:0]               sts_words
);

    localparam int GW = clog2(N_CH);
    localparam int W  = AXIS_TDATA_WIDTH;

    arb_state_t             state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [BURST_WIDTH-1:0] count_q, count_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;

    logic [GW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   valid_g;
    logic [W-1:0]           ch_data [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_slice
            assign ch_data[gi] = s_axis_tdata[gi*W +: W];
        end
    endgenerate

    axis_rr_pick #(
        .N_CH (N_CH),
        .GW   (GW)
    ) u_pick (
        .req_i (s_axis_tvalid),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            ptr_q   <= GW'(N_CH - 1);
            grant_q <= '0;
            count_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            count_q <= count_d;
            burst_q <= burst_d;
        end
    end

    assign valid_g = s_axis_tvalid[grant_q];

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant_d         = grant_q;
        count_d         = count_q;
        burst_d         = burst_q;
        s_axis_tready   = '0;
        fifo_write_wren = 1'b0;
        fifo_write_data = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    burst_d = (cfg_burst == '0) ? BURST_WIDTH'(1) : cfg_burst;
                    count_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                s_axis_tready[grant_q] = ~fifo_write_full;
                fifo_write_wren        = valid_g & ~fifo_write_full;
                if (fifo_write_wren) begin
                    fifo_write_data = ch_data[grant_q];
                    count_d         = count_q + BURST_WIDTH'(1);
                end
                // A valid gap releases even while full; full alone just holds.
                if (!valid_g || (fifo_write_wren && (count_q == burst_q - BURST_WIDTH'(1)))) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sts_grant = grant_q;
    assign sts_busy  = (state_q == GRANT);

`ifdef ARB_STATS_EN
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_stats
            logic [31:0] words_q;
            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    words_q <= '0;
                end else if (fifo_write_wren && (grant_q == GW'(gi))) begin
                    words_q <= words_q + 32'd1;
                end
            end
            assign sts_words[gi*32 +: 32] = words_q;
        end
    endgenerate
`else
    assign sts_words = '0;
`endif

endmodule : axis_fifo_arbiter

// File: tb/tb_axis_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_arbiter
// Directed checks of the round-robin FIFO arbiter with N_CH=4, W=32.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge. Define ARB_STATS_EN for the word-counter scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_fifo_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int BW = 16;

    logic             aclk;
    logic             areset;
    logic [BW-1:0]    cfg_burst;
    logic [N*W-1:0]   s_axis_tdata;
    logic [N-1:0]     s_axis_tvalid;
    logic [N-1:0]     s_axis_tready;
    logic             fifo_write_full;
    logic [W-1:0]     fifo_write_data;
    logic             fifo_write_wren;
    logic [1:0]       sts_grant;
    logic             sts_busy;
    logic [N*32-1:0]  sts_words;

    int total_cnt;
    int bad_cnt;

    axis_fifo_arbiter #(
        .N_CH             (N),
        .AXIS_TDATA_WIDTH (W),
        .BURST_WIDTH      (BW)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_burst       (cfg_burst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .fifo_write_full (fifo_write_full),
        .fifo_write_data (fifo_write_data),
        .fifo_write_wren (fifo_write_wren),
        .sts_grant       (sts_grant),
        .sts_busy        (sts_busy),
        .sts_words       (sts_words)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Fixed per-channel data pattern.
    function automatic logic [W-1:0] ch_word(input int ch);
        return 32'hC0DE_0000 + 32'(ch) * 32'h0000_0111;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Checks one cycle on the falling edge, then moves to just after the
    // next rising edge so the caller can change inputs.
    task automatic exp_cyc(input string tag, input bit wren_e, input int grant_e, input bit busy_e);
        logic [N-1:0] rdy_e;
        @(negedge aclk);
        rdy_e = '0;
        if (busy_e && !fifo_write_full) rdy_e[grant_e] = 1'b1;
        chk({tag, ".wren"},  64'(fifo_write_wren), 64'(wren_e));
        chk({tag, ".busy"},  64'(sts_busy),        64'(busy_e));
        chk({tag, ".grant"}, 64'(sts_grant),       64'(grant_e));
        chk({tag, ".tready"}, 64'(s_axis_tready),  64'(rdy_e));
        chk({tag, ".data"},  64'(fifo_write_data), wren_e ? 64'(ch_word(grant_e)) : 64'd0);
        if (fifo_write_wren)
            $display("xfer %s ch=%0d data=%h", tag, sts_grant, fifo_write_data);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        total_cnt       = 0;
        bad_cnt         = 0;
        areset          = 1'b1;
        cfg_burst       = '0;
        s_axis_tvalid   = '0;
        fifo_write_full = 1'b0;
        for (int i = 0; i < N; i++) s_axis_tdata[i*W +: W] = ch_word(i);

        // Reset state while held, with traffic present.
        s_axis_tvalid = 4'b1111;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst.tready", 64'(s_axis_tready),   64'd0);
        chk("rst.wren",   64'(fifo_write_wren), 64'd0);
        chk("rst.data",   64'(fifo_write_data), 64'd0);
        chk("rst.busy",   64'(sts_busy),        64'd0);
        chk("rst.grant",  64'(sts_grant),       64'd0);
        chk("rst.words",  64'(sts_words[63:0]), 64'd0);

        // 1: all valid, burst 3 -> 0,1,2,3,0 with one bubble between grants.
        do_reset();
        cfg_burst     = 16'd3;
        s_axis_tvalid = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_cyc("t1.idle", 1'b0, (r == 0) ? 0 : (r - 1) % N, 1'b0);
            for (int w = 0; w < 3; w++) exp_cyc("t1.xfer", 1'b1, r % N, 1'b1);
        end
`ifndef ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("t1.words_off", 64'(sts_words[i*32 +: 32]), 64'd0);
`endif

        // 2: only ch2 valid, cfg_burst 0 -> one word every two cycles.
        do_reset();
        cfg_burst     = 16'd0;
        s_axis_tvalid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            exp_cyc("t2.idle", 1'b0, (k == 0) ? 0 : 2, 1'b0);
            exp_cyc("t2.xfer", 1'b1, 2, 1'b1);
        end

        // 3: ch1, burst 8, full for 5 cycles after word 2.
        do_reset();
        cfg_burst     = 16'd8;
        s_axis_tvalid = 4'b0010;
        exp_cyc("t3.idle", 1'b0, 0, 1'b0);
        for (int w = 0; w < 2; w++) exp_cyc("t3.xfer", 1'b1, 1, 1'b1);
        fifo_write_full = 1'b1;
        cfg_burst       = 16'd1;   // mid-burst change must not shorten this grant
        for (int c = 0; c < 5; c++) exp_cyc("t3.full", 1'b0, 1, 1'b1);
        fifo_write_full = 1'b0;
        for (int w = 0; w < 6; w++) exp_cyc("t3.xfer2", 1'b1, 1, 1'b1);
        exp_cyc("t3.rel", 1'b0, 1, 1'b0);

        // 4: ch0, burst 8, tvalid gap after 4 words -> next grant ch1.
        do_reset();
        cfg_burst     = 16'd8;
        s_axis_tvalid = 4'b0011;
        exp_cyc("t4.idle", 1'b0, 0, 1'b0);
        for (int w = 0; w < 4; w++) exp_cyc("t4.xfer", 1'b1, 0, 1'b1);
        s_axis_tvalid = 4'b0010;
        exp_cyc("t4.gap", 1'b0, 0, 1'b1);
        s_axis_tvalid = 4'b0011;
        exp_cyc("t4.idle2", 1'b0, 0, 1'b0);
        exp_cyc("t4.next", 1'b1, 1, 1'b1);

        // 5: async reset in the middle of ch1's burst.
        do_reset();
        cfg_burst     = 16'd3;
        s_axis_tvalid = 4'b1111;
        exp_cyc("t5.idle", 1'b0, 0, 1'b0);
        for (int w = 0; w < 3; w++) exp_cyc("t5.xfer", 1'b1, 0, 1'b1);
        exp_cyc("t5.idle2", 1'b0, 0, 1'b0);
        exp_cyc("t5.xfer1", 1'b1, 1, 1'b1);
        areset = 1'b1;
        #1;
        chk("t5.rst.tready", 64'(s_axis_tready),   64'd0);
        chk("t5.rst.wren",   64'(fifo_write_wren), 64'd0);
        chk("t5.rst.busy",   64'(sts_busy),        64'd0);
        chk("t5.rst.grant",  64'(sts_grant),       64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_cyc("t5.idle3", 1'b0, 0, 1'b0);
        exp_cyc("t5.first", 1'b1, 0, 1'b1);

`ifdef ARB_STATS_EN
        // 6: two full rounds at burst 3 -> 6 words per channel.
        do_reset();
        cfg_burst     = 16'd3;
        s_axis_tvalid = 4'b1111;
        for (int r = 0; r < 2 * N; r++) begin
            exp_cyc("t6.idle", 1'b0, (r == 0) ? 0 : (r - 1) % N, 1'b0);
            for (int w = 0; w < 3; w++) exp_cyc("t6.xfer", 1'b1, r % N, 1'b1);
        end
        s_axis_tvalid = 4'b0000;
        @(negedge aclk);
        for (int i = 0; i < N; i++) chk("t6.words", 64'(sts_words[i*32 +: 32]), 64'd6);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad_cnt++;
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_axis_fifo_arbiter
